// File: rtl/magnitude_sched_pkg.sv
// Shared types and descriptor layout for the magnitude job scheduler.
// A descriptor packs {RADDR, LADDR, WADDR, NUM, SIZE} with SIZE in the LSBs.
package magnitude_sched_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    WAIT_ACK,
    RUN,
    FAULT_ST
  } state_e;

  localparam int NUM_W     = 11;
  localparam int SIZE_W    = 19;
  localparam int OFF_SIZE  = 0;
  localparam int OFF_NUM   = OFF_SIZE + SIZE_W;
  localparam int OFF_WADDR = OFF_NUM + NUM_W;

  function automatic int off_laddr(input int aw);
    return OFF_WADDR + aw;
  endfunction

  function automatic int off_raddr(input int aw);
    return OFF_WADDR + 2 * aw;
  endfunction

  function automatic int desc_w(input int aw);
    return 3 * aw + NUM_W + SIZE_W;
  endfunction

endpackage

// File: rtl/magnitude_job_fifo.sv
// Synchronous descriptor FIFO; rdata_o always shows the current head entry.
// Storage is not reset: only pointers and occupancy carry meaning.
module magnitude_job_fifo
  import magnitude_sched_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = desc_w(32)
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         wdata_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, rd_q;
  logic [AW:0]      cnt_q;
  logic             do_push, do_pop;

  assign full_o  = (cnt_q == (AW + 1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign rdata_o = mem_q[rd_q];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + AW'(1);
      if (do_pop)  rd_q <= rd_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + (AW + 1)'(1);
        2'b01:   cnt_q <= cnt_q - (AW + 1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q] <= wdata_i;
  end

endmodule

// File: rtl/magnitude_job_scheduler.sv
// Queues magnitude-engine jobs and launches them one at a time, holding the
// head job's parameters steady until DONE; adds IRQ, bad-job and watchdog status.
module magnitude_job_scheduler
  import magnitude_sched_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int WDOG_WIDTH = 24
) (
  input  logic                      CSI_CLOCK_CLK,
  input  logic                      CSI_CLOCK_RESET,
  input  logic                      JOB_VALID,
  output logic                      JOB_READY,
  input  logic [ADDR_WIDTH-1:0]     JOB_RADDR,
  input  logic [ADDR_WIDTH-1:0]     JOB_LADDR,
  input  logic [ADDR_WIDTH-1:0]     JOB_WADDR,
  input  logic [NUM_W-1:0]          JOB_NUM,
  input  logic [SIZE_W-1:0]         JOB_SIZE,
  output logic                      ENG_START,
  output logic [ADDR_WIDTH-1:0]     ENG_RADDR,
  output logic [ADDR_WIDTH-1:0]     ENG_LADDR,
  output logic [ADDR_WIDTH-1:0]     ENG_WADDR,
  output logic [NUM_W-1:0]          ENG_NUM,
  output logic [SIZE_W-1:0]         ENG_SIZE,
  input  logic                      ENG_INIT_START,
  input  logic                      ENG_DONE,
  input  logic                      IRQ_EN,
  input  logic                      IRQ_CLEAR,
  input  logic                      ERR_CLEAR,
  output logic                      IRQ,
  output logic                      BUSY,
  output logic                      FAULT,
  output logic                      BAD_JOB,
  output logic [$clog2(DEPTH):0]    FIFO_COUNT,
  output logic [15:0]               JOBS_DONE,
  input  logic [WDOG_WIDTH-1:0]     WDOG_LIMIT
);

  localparam int DW = desc_w(ADDR_WIDTH);

  state_e                state_q;
  logic [DW-1:0]         head_q;
  logic [WDOG_WIDTH-1:0] wdog_q;
  logic [15:0]           done_cnt_q;
  logic                  start_q, irq_q, fault_q, bad_q;

  logic          fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [DW-1:0] fifo_head, fifo_wdata;
  logic          accept, bad_desc, wdog_hit, done_ok;

  assign accept     = JOB_VALID && JOB_READY;
  assign bad_desc   = (JOB_NUM == '0) || (JOB_SIZE == '0);
  assign fifo_push  = accept && !bad_desc;
  assign fifo_wdata = {JOB_RADDR, JOB_LADDR, JOB_WADDR, JOB_NUM, JOB_SIZE};

  assign wdog_hit = ((state_q == WAIT_ACK) || (state_q == RUN)) &&
                    (WDOG_LIMIT != '0) && (wdog_q == WDOG_LIMIT);
  assign done_ok  = (state_q == RUN) && ENG_DONE && !wdog_hit;
  // A faulted job is dropped so the queue does not relaunch it after ERR_CLEAR.
  assign fifo_pop = done_ok || wdog_hit;

  magnitude_job_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (DW)
  ) u_fifo (
    .clk_i   (CSI_CLOCK_CLK),
    .rst_i   (CSI_CLOCK_RESET),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .wdata_i (fifo_wdata),
    .rdata_o (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (FIFO_COUNT)
  );

  always_ff @(posedge CSI_CLOCK_CLK) begin
    if (CSI_CLOCK_RESET) begin
      state_q    <= IDLE;
      head_q     <= '0;
      wdog_q     <= '0;
      done_cnt_q <= '0;
      start_q    <= 1'b0;
      irq_q      <= 1'b0;
      fault_q    <= 1'b0;
      bad_q      <= 1'b0;
    end else begin
      start_q <= 1'b0;
      case (state_q)
        IDLE: begin
          // Head is captured on entry so ENG_* are valid during the START cycle.
          if (!fifo_empty && !fault_q) begin
            state_q <= LAUNCH;
            head_q  <= fifo_head;
            start_q <= 1'b1;
          end
        end
        LAUNCH: begin
          wdog_q  <= '0;
          state_q <= WAIT_ACK;
        end
        WAIT_ACK, RUN: begin
          if (wdog_hit) begin
            state_q <= FAULT_ST;
            fault_q <= 1'b1;
          end else begin
            if (wdog_q != '1) wdog_q <= wdog_q + WDOG_WIDTH'(1);
            if (state_q == WAIT_ACK && ENG_INIT_START) state_q <= RUN;
            if (done_ok) begin
              state_q    <= IDLE;
              done_cnt_q <= done_cnt_q + 16'd1;
            end
          end
        end
        FAULT_ST: begin
          if (ERR_CLEAR) begin
            state_q <= IDLE;
            fault_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase

      if (done_ok && IRQ_EN) irq_q <= 1'b1;
      else if (IRQ_CLEAR)    irq_q <= 1'b0;

      if (accept && bad_desc) bad_q <= 1'b1;
      else if (ERR_CLEAR)     bad_q <= 1'b0;
    end
  end

  assign JOB_READY = !CSI_CLOCK_RESET && !fifo_full;
  assign ENG_START = start_q;
  assign ENG_RADDR = head_q[off_raddr(ADDR_WIDTH) +: ADDR_WIDTH];
  assign ENG_LADDR = head_q[off_laddr(ADDR_WIDTH) +: ADDR_WIDTH];
  assign ENG_WADDR = head_q[OFF_WADDR +: ADDR_WIDTH];
  assign ENG_NUM   = head_q[OFF_NUM +: NUM_W];
  assign ENG_SIZE  = head_q[OFF_SIZE +: SIZE_W];
  assign IRQ       = irq_q;
  assign FAULT     = fault_q;
  assign BAD_JOB   = bad_q;
  assign JOBS_DONE = done_cnt_q;
  assign BUSY      = (state_q != IDLE) || !fifo_empty;

endmodule

// File: tb/tb_magnitude_job_scheduler.sv
// Scoreboard bench for magnitude_job_scheduler: stimulus queues expected jobs,
// a monitor checks every launch and parameter stability against that queue.
module tb_magnitude_job_scheduler;

  localparam int DEPTH = 4;
  localparam int AW    = 32;
  localparam int WW    = 24;

  typedef struct {
    logic [AW-1:0] r;
    logic [AW-1:0] l;
    logic [AW-1:0] w;
    logic [10:0]   n;
    logic [18:0]   s;
  } job_t;

  logic          clk;
  logic          CSI_CLOCK_RESET;
  logic          JOB_VALID, JOB_READY;
  logic [AW-1:0] JOB_RADDR, JOB_LADDR, JOB_WADDR;
  logic [10:0]   JOB_NUM;
  logic [18:0]   JOB_SIZE;
  logic          ENG_START;
  logic [AW-1:0] ENG_RADDR, ENG_LADDR, ENG_WADDR;
  logic [10:0]   ENG_NUM;
  logic [18:0]   ENG_SIZE;
  logic          ENG_INIT_START, ENG_DONE;
  logic          IRQ_EN, IRQ_CLEAR, ERR_CLEAR;
  logic          IRQ, BUSY, FAULT, BAD_JOB;
  logic [2:0]    FIFO_COUNT;
  logic [15:0]   JOBS_DONE;
  logic [WW-1:0] WDOG_LIMIT;

  magnitude_job_scheduler #(.DEPTH(DEPTH), .ADDR_WIDTH(AW), .WDOG_WIDTH(WW)) dut (
    .CSI_CLOCK_CLK(clk), .CSI_CLOCK_RESET(CSI_CLOCK_RESET),
    .JOB_VALID(JOB_VALID), .JOB_READY(JOB_READY),
    .JOB_RADDR(JOB_RADDR), .JOB_LADDR(JOB_LADDR), .JOB_WADDR(JOB_WADDR),
    .JOB_NUM(JOB_NUM), .JOB_SIZE(JOB_SIZE),
    .ENG_START(ENG_START), .ENG_RADDR(ENG_RADDR), .ENG_LADDR(ENG_LADDR),
    .ENG_WADDR(ENG_WADDR), .ENG_NUM(ENG_NUM), .ENG_SIZE(ENG_SIZE),
    .ENG_INIT_START(ENG_INIT_START), .ENG_DONE(ENG_DONE),
    .IRQ_EN(IRQ_EN), .IRQ_CLEAR(IRQ_CLEAR), .ERR_CLEAR(ERR_CLEAR),
    .IRQ(IRQ), .BUSY(BUSY), .FAULT(FAULT), .BAD_JOB(BAD_JOB),
    .FIFO_COUNT(FIFO_COUNT), .JOBS_DONE(JOBS_DONE), .WDOG_LIMIT(WDOG_LIMIT)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int   n_chk = 0;
  int   n_fail = 0;
  job_t exp_q[$];
  int   exp_done = 0;
  bit   exp_bad = 0;
  int   n_starts = 0;
  int   last_start_cyc = 0;
  bit   ack_en = 1;
  int   done_delay = 20;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard monitor: every launch must match the oldest queued good job,
  // and the launched parameters must hold until the engine reports DONE.
  initial begin
    job_t cur;
    bit   in_job, b2b;
    int   done_cyc;
    in_job = 0; b2b = 0; done_cyc = 0;
    cur = '{default: '0};
    forever begin
      @(negedge clk);
      if (CSI_CLOCK_RESET) begin
        in_job = 0;
        b2b = 0;
        exp_q.delete();
        exp_done = 0;
      end else begin
        if (in_job && !ENG_START)
          check("eng_params_stable", {ENG_RADDR, ENG_LADDR, ENG_WADDR, ENG_NUM, ENG_SIZE},
                {cur.r, cur.l, cur.w, cur.n, cur.s});
        if (ENG_START) begin
          n_starts++;
          last_start_cyc = cyc;
          if (b2b) check("done_to_start_gap", cyc - done_cyc, 2);
          b2b = 0;
          check("start_has_queued_job", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) begin
            cur = exp_q.pop_front();
            check("launch_params", {ENG_RADDR, ENG_LADDR, ENG_WADDR, ENG_NUM, ENG_SIZE},
                  {cur.r, cur.l, cur.w, cur.n, cur.s});
            in_job = 1;
          end
        end
        if (ENG_DONE && in_job) begin
          in_job = 0;
          exp_done++;
          done_cyc = cyc;
          b2b = (exp_q.size() != 0);
        end
      end
    end
  end

  // Engine model: acknowledge one cycle after START, DONE after done_delay cycles.
  initial begin
    int wait_n;
    ENG_INIT_START = 1'b0;
    ENG_DONE = 1'b0;
    forever begin
      @(negedge clk);
      if (ENG_START && !CSI_CLOCK_RESET) begin
        @(posedge clk); #1;
        ENG_INIT_START = ack_en;
        @(posedge clk); #1;
        ENG_INIT_START = 1'b0;
        if (ack_en) begin
          wait_n = done_delay;
          while (wait_n > 0 && !CSI_CLOCK_RESET) begin
            @(posedge clk); #1;
            wait_n--;
          end
          if (!CSI_CLOCK_RESET) begin
            ENG_DONE = 1'b1;
            @(posedge clk); #1;
            ENG_DONE = 1'b0;
          end
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  task automatic push_job(input job_t j, input int max_wait, output bit acc);
    @(posedge clk); #1;
    JOB_VALID = 1'b1;
    JOB_RADDR = j.r; JOB_LADDR = j.l; JOB_WADDR = j.w;
    JOB_NUM = j.n; JOB_SIZE = j.s;
    acc = 0;
    for (int i = 0; i < max_wait && !acc; i++) begin
      @(negedge clk);
      if (JOB_READY) begin
        acc = 1;
        if (j.n != 0 && j.s != 0) exp_q.push_back(j);
        else exp_bad = 1;
      end
      @(posedge clk); #1;
    end
    JOB_VALID = 1'b0;
  endtask

  task automatic wait_idle(input int max_cyc, input string tag);
    int k;
    k = 0;
    @(negedge clk);
    while (BUSY && k < max_cyc) begin
      @(negedge clk);
      k++;
    end
    check(tag, BUSY, 0);
  endtask

  task automatic pulse_irq_clear();
    @(posedge clk); #1; IRQ_CLEAR = 1'b1;
    @(posedge clk); #1; IRQ_CLEAR = 1'b0;
  endtask

  task automatic pulse_err_clear();
    @(posedge clk); #1; ERR_CLEAR = 1'b1;
    @(posedge clk); #1; ERR_CLEAR = 1'b0;
    exp_bad = 0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_ready"}, JOB_READY, 1);
    check({tag, "_start"}, ENG_START, 0);
    check({tag, "_irq"}, IRQ, 0);
    check({tag, "_busy"}, BUSY, 0);
    check({tag, "_fault"}, FAULT, 0);
    check({tag, "_bad"}, BAD_JOB, 0);
    check({tag, "_count"}, FIFO_COUNT, 0);
    check({tag, "_jobs_done"}, JOBS_DONE, 0);
    check({tag, "_eng_params"}, {ENG_RADDR, ENG_LADDR, ENG_WADDR, ENG_NUM, ENG_SIZE}, 0);
  endtask

  function automatic job_t rand_job();
    job_t j;
    j.r = $urandom; j.l = $urandom; j.w = $urandom;
    j.n = 11'($urandom_range(1, 2047));
    j.s = 19'($urandom_range(1, 524287));
    return j;
  endfunction

  initial begin
    job_t j;
    bit   acc;
    int   s0, jd0, fault_cyc, k, good;

    CSI_CLOCK_RESET = 1'b1;
    JOB_VALID = 0; JOB_RADDR = 0; JOB_LADDR = 0; JOB_WADDR = 0; JOB_NUM = 0; JOB_SIZE = 0;
    IRQ_EN = 0; IRQ_CLEAR = 0; ERR_CLEAR = 0; WDOG_LIMIT = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("ready_in_reset", JOB_READY, 0);
    @(posedge clk); #1;
    CSI_CLOCK_RESET = 1'b0;
    @(negedge clk);
    check_reset_values("por");

    // Single job: one START, no bypass, IRQ held until cleared.
    IRQ_EN = 1; done_delay = 20; s0 = n_starts; jd0 = exp_done;
    j = '{r: 32'h1000, l: 32'h2000, w: 32'h3000, n: 11'd2, s: 19'd4};
    push_job(j, 1, acc);
    check("single_push_acc", acc, 1);
    @(negedge clk);
    check("count_after_push", FIFO_COUNT, 1);
    check("no_bypass_start", ENG_START, 0);
    @(negedge clk);
    check("start_latency", ENG_START, 1);
    wait_idle(200, "single_idle");
    check("single_one_start", n_starts - s0, 1);
    check("single_jobs_done", JOBS_DONE, 16'(jd0 + 1));
    check("single_irq_set", IRQ, 1);
    repeat (5) @(negedge clk);
    check("single_irq_held", IRQ, 1);
    pulse_irq_clear();
    @(negedge clk);
    check("single_irq_cleared", IRQ, 0);

    // Backlog: fill the FIFO while the engine is busy.
    done_delay = 30; jd0 = exp_done;
    for (int i = 0; i < 4; i++) begin
      push_job(rand_job(), 1, acc);
      check("backlog_push_acc", acc, 1);
    end
    @(negedge clk);
    check("ready_low_when_full", JOB_READY, 0);
    check("count_full", FIFO_COUNT, 4);
    j = rand_job();
    push_job(j, 1, acc);
    check("push_rejected_full", acc, 0);
    push_job(j, 300, acc);
    check("push5_accepted", acc, 1);
    wait_idle(1000, "backlog_idle");
    check("backlog_jobs_done", JOBS_DONE, 16'(jd0 + 5));

    // Zero NUM / zero SIZE jobs are dropped and flagged.
    s0 = n_starts;
    j = rand_job(); j.n = 0;
    push_job(j, 1, acc);
    j = rand_job(); j.s = 0;
    push_job(j, 1, acc);
    repeat (5) @(negedge clk);
    check("bad_job_set", BAD_JOB, 1);
    check("bad_count_zero", FIFO_COUNT, 0);
    check("bad_no_start", n_starts - s0, 0);
    pulse_err_clear();
    @(negedge clk);
    check("bad_job_cleared", BAD_JOB, 0);

    // Watchdog: no acknowledge; the count reaches 10 in the 11th cycle after
    // LAUNCH and FAULT is registered at the end of that cycle.
    WDOG_LIMIT = 24'd10; ack_en = 0; s0 = n_starts;
    push_job(rand_job(), 1, acc);
    push_job(rand_job(), 1, acc);
    k = 0; fault_cyc = -1;
    while (k < 60 && fault_cyc < 0) begin
      @(negedge clk);
      if (FAULT) fault_cyc = cyc;
      k++;
    end
    check("fault_latency", fault_cyc - last_start_cyc, 12);
    repeat (10) @(negedge clk);
    check("fault_sticky", FAULT, 1);
    check("fault_no_relaunch", n_starts - s0, 1);
    check("fault_dropped_head", FIFO_COUNT, 1);
    check("fault_busy", BUSY, 1);
    ack_en = 1; WDOG_LIMIT = '0; jd0 = exp_done;
    pulse_err_clear();
    @(negedge clk);
    check("fault_cleared", FAULT, 0);
    wait_idle(200, "fault_recover_idle");
    check("fault_next_started", n_starts - s0, 2);
    check("fault_recover_done", JOBS_DONE, 16'(jd0 + 1));

    // IRQ set wins over a simultaneous IRQ_CLEAR.
    pulse_irq_clear();
    @(negedge clk);
    check("irq_pre_clear", IRQ, 0);
    IRQ_EN = 1; done_delay = 6;
    push_job(rand_job(), 1, acc);
    k = 0;
    @(negedge clk);
    while (!ENG_DONE && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("done_seen", ENG_DONE, 1);
    IRQ_CLEAR = 1'b1;
    @(posedge clk); #1;
    IRQ_CLEAR = 1'b0;
    @(negedge clk);
    check("irq_set_beats_clear", IRQ, 1);
    pulse_irq_clear();
    wait_idle(50, "irq_idle");

    // Randomised jobs, some bad, with random engine latency and gaps.
    jd0 = exp_done; good = 0;
    for (int i = 0; i < 25; i++) begin
      j = rand_job();
      if ($urandom_range(0, 7) == 0) begin
        if ($urandom_range(0, 1) == 0) j.n = 0;
        else j.s = 0;
      end else begin
        good++;
      end
      IRQ_EN = 1'($urandom_range(0, 1));
      done_delay = $urandom_range(0, 15);
      push_job(j, 300, acc);
      check("random_push_acc", acc, 1);
      repeat ($urandom_range(0, 3)) @(posedge clk);
    end
    wait_idle(3000, "random_idle");
    check("random_jobs_done", JOBS_DONE, 16'(jd0 + good));
    check("random_bad_flag", BAD_JOB, exp_bad);
    pulse_err_clear();
    pulse_irq_clear();

    // Reset while a job is running.
    done_delay = 50;
    push_job(rand_job(), 1, acc);
    push_job(rand_job(), 1, acc);
    repeat (5) @(negedge clk);
    check("pre_reset_busy", BUSY, 1);
    @(posedge clk); #1;
    CSI_CLOCK_RESET = 1'b1;
    @(negedge clk);
    check("ready_in_midreset", JOB_READY, 0);
    repeat (2) @(posedge clk);
    #1;
    CSI_CLOCK_RESET = 1'b0;
    @(negedge clk);
    check_reset_values("midrst");
    done_delay = 3;
    push_job(rand_job(), 1, acc);
    wait_idle(100, "post_reset_idle");
    check("post_reset_jobs_done", JOBS_DONE, 1);

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
